// File: rtl/mage_pkg.sv
// Shared defaults and types for the stream-group memory front end.
package mage_pkg;

    localparam int N_AGE_PER_STREAM   = 4;
    localparam int N_BANKS_PER_STREAM = 4;
    localparam int MAGE_DATA_W        = 32;
    localparam int MAGE_ADDR_W        = 16;
    localparam int MAGE_MEM_LAT       = 1;

    localparam int SRC_W = $clog2(N_AGE_PER_STREAM);

    // In-flight bank access tag: whether a load is pending and which AGE issued it.
    typedef struct packed {
        logic             load_valid;
        logic [SRC_W-1:0] src;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer, pointer moves just past the winner.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = IW'(j);
                gnt_o[j] = 1'b1;
            end
        end
        any_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_o) ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/stream_bank_arbiter.sv
// Per-stream bank arbiter: round-robin grant per bank, registered bank issue,
// and a latency-matched tag pipeline that routes load data back to its AGE.
module stream_bank_arbiter
    import mage_pkg::*;
#(
    parameter int N_REQ   = N_AGE_PER_STREAM,
    parameter int N_BANKS = N_BANKS_PER_STREAM,
    parameter int ADDR_W  = MAGE_ADDR_W,
    parameter int DATA_W  = MAGE_DATA_W,
    parameter int MEM_LAT = MAGE_MEM_LAT
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ-1:0][N_BANKS-1:0]    req_bank_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]     req_addr_i,
    input  logic [N_REQ-1:0]                 req_lns_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]     req_wdata_i,
    output logic [N_BANKS-1:0]               bank_req_o,
    output logic [N_BANKS-1:0]               bank_we_o,
    output logic [N_BANKS-1:0][ADDR_W-1:0]   bank_addr_o,
    output logic [N_BANKS-1:0][DATA_W-1:0]   bank_wdata_o,
    input  logic [N_BANKS-1:0][DATA_W-1:0]   bank_rdata_i,
    output logic [N_REQ-1:0]                 rsp_valid_o,
    output logic [N_REQ-1:0][DATA_W-1:0]     rsp_rdata_o,
    output logic [N_BANKS-1:0]               conflict_o,
    output logic                             illegal_o
);

    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Same layout as mage_pkg::tag_t, sized from this instance's N_REQ.
    typedef struct packed {
        logic          load_valid;
        logic [SW-1:0] src;
    } btag_t;

    logic [N_REQ-1:0]                legal;
    logic [N_BANKS-1:0][N_REQ-1:0]   cand, gnt;
    logic [N_BANKS-1:0][SW-1:0]      win;
    logic [N_BANKS-1:0]              any;
    logic [N_BANKS-1:0]              conflict_d;

    logic [N_BANKS-1:0]              bank_req_q, bank_we_q, conflict_q;
    logic [N_BANKS-1:0][ADDR_W-1:0]  bank_addr_q;
    logic [N_BANKS-1:0][DATA_W-1:0]  bank_wdata_q;
    btag_t [N_BANKS-1:0][MEM_LAT:0]  tag_q;
    logic [N_REQ-1:0]                rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                            illegal_q, illegal_d;

    // Zero or multi-hot bank vectors are excluded from every bank's candidates.
    always_comb begin
        legal      = '0;
        cand       = '0;
        conflict_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            legal[k] = $onehot(req_bank_i[k]);
            for (int b = 0; b < N_BANKS; b++)
                cand[b][k] = req_valid_i[k] & legal[k] & req_bank_i[k][b];
        end
        for (int b = 0; b < N_BANKS; b++)
            conflict_d[b] = (cand[b] & (cand[b] - 1'b1)) != '0;
        illegal_d = illegal_q | (|(req_valid_i & ~legal));
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_arb
        rr_arbiter #(.N(N_REQ)) u_arb (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .req_i   (cand[b]),
            .gnt_o   (gnt[b]),
            .idx_o   (win[b]),
            .any_o   (any[b])
        );
    end

    always_comb begin
        req_ready_o = '0;
        for (int b = 0; b < N_BANKS; b++) req_ready_o = req_ready_o | gnt[b];
    end

    // Tag stage s lines up with bank cycle t+1+s; the last stage meets rdata.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        for (int b = 0; b < N_BANKS; b++) begin
            if (tag_q[b][MEM_LAT].load_valid) begin
                rsp_valid_d[tag_q[b][MEM_LAT].src] = 1'b1;
                rsp_rdata_d[tag_q[b][MEM_LAT].src] = bank_rdata_i[b];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_req_q   <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            conflict_q   <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            illegal_q    <= 1'b0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                bank_req_q[b] <= any[b];
                bank_we_q[b]  <= any[b] & ~req_lns_i[win[b]];
                if (any[b]) begin
                    bank_addr_q[b]  <= req_addr_i[win[b]];
                    bank_wdata_q[b] <= req_wdata_i[win[b]];
                end
                tag_q[b][0] <= '{load_valid: any[b] & req_lns_i[win[b]], src: win[b]};
                for (int s = 1; s <= MEM_LAT; s++) tag_q[b][s] <= tag_q[b][s-1];
            end
            conflict_q  <= conflict_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bank_req_o   = bank_req_q;
    assign bank_we_o    = bank_we_q;
    assign bank_addr_o  = bank_addr_q;
    assign bank_wdata_o = bank_wdata_q;
    assign conflict_o   = conflict_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_stream_bank_arbiter.sv
// Directed and scoreboard bench for stream_bank_arbiter; one instance at
// MEM_LAT=1 and one at MEM_LAT=3 share the same request stimulus.
module tb_stream_bank_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        valid, lns;
    logic [3:0][3:0]   bank;
    logic [3:0][15:0]  addr;
    logic [3:0][31:0]  wdata;

    logic [3:0]        ready1, breq1, we1, conf1, rspv1;
    logic [3:0]        ready3, breq3, we3, conf3, rspv3;
    logic [3:0][15:0]  baddr1, baddr3;
    logic [3:0][31:0]  bwd1, bwd3, rd1, rd3, rspd1, rspd3, p1, p2;
    logic              ill1, ill3;

    int checks = 0;
    int passed = 0;

    stream_bank_arbiter #(.MEM_LAT(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid), .req_ready_o(ready1),
        .req_bank_i(bank), .req_addr_i(addr), .req_lns_i(lns), .req_wdata_i(wdata),
        .bank_req_o(breq1), .bank_we_o(we1), .bank_addr_o(baddr1), .bank_wdata_o(bwd1),
        .bank_rdata_i(rd1), .rsp_valid_o(rspv1), .rsp_rdata_o(rspd1),
        .conflict_o(conf1), .illegal_o(ill1));

    stream_bank_arbiter #(.MEM_LAT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid), .req_ready_o(ready3),
        .req_bank_i(bank), .req_addr_i(addr), .req_lns_i(lns), .req_wdata_i(wdata),
        .bank_req_o(breq3), .bank_we_o(we3), .bank_addr_o(baddr3), .bank_wdata_o(bwd3),
        .bank_rdata_i(rd3), .rsp_valid_o(rspv3), .rsp_rdata_o(rspd3),
        .conflict_o(conf3), .illegal_o(ill3));

    function automatic logic [31:0] memval(int b, logic [15:0] a);
        return {a[11:0], 4'(b), 16'hCAFE};
    endfunction

    // Bank models: read data appears MEM_LAT cycles after the registered request.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            rd1[b] <= memval(b, baddr1[b]);
            p1[b]  <= memval(b, baddr3[b]);
        end
        p2  <= p1;
        rd3 <= p2;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        valid = '0; lns = '0; bank = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk); @(negedge clk);
        checks++; if ({ready1, breq1, we1, conf1, rspv1, ill1} !== 21'd0)
            $display("FAIL reset_ctrl1: got %b want 0", {ready1, breq1, we1, conf1, rspv1, ill1}); else passed++;
        checks++; if ({baddr1, bwd1, rspd1} !== '0)
            $display("FAIL reset_data1: got %h want 0", {baddr1, bwd1, rspd1}); else passed++;
        checks++; if ({breq3, we3, conf3, rspv3, ill3, baddr3, bwd3, rspd3} !== '0)
            $display("FAIL reset_dut3: outputs not all zero"); else passed++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        tick();
        valid = 4'b0001; bank[0] = 4'b0100; addr[0] = 16'h0010; lns[0] = 1'b1;
        @(negedge clk);
        checks++; if (ready1 !== 4'b0001) $display("FAIL single_ready: got %b want 0001", ready1); else passed++;
        tick(); idle();
        @(negedge clk);
        checks++; if ({breq1, we1} !== 8'b0100_0000) $display("FAIL single_issue: got %b want 01000000", {breq1, we1}); else passed++;
        checks++; if (baddr1[2] !== 16'h0010) $display("FAIL single_addr: got %h want 0010", baddr1[2]); else passed++;
        tick(); @(negedge clk);
        checks++; if (rspv1 !== 4'b0000) $display("FAIL single_early_rsp: got %b want 0000", rspv1); else passed++;
        tick(); @(negedge clk);
        checks++; if (rspv1 !== 4'b0001) $display("FAIL single_rsp_valid: got %b want 0001", rspv1); else passed++;
        checks++; if (rspd1[0] !== 32'h0102CAFE) $display("FAIL single_rsp_data: got %h want 0102cafe", rspd1[0]); else passed++;
        tick(); @(negedge clk);
        checks++; if (rspv1 !== 4'b0000) $display("FAIL single_rsp_pulse: got %b want 0000", rspv1); else passed++;
        checks++; if (rspd1[0] !== 32'h0102CAFE) $display("FAIL single_rsp_hold: got %h want 0102cafe", rspd1[0]); else passed++;
    endtask

    task automatic test_rr_bank1();
        tick();
        valid = 4'b1111; lns = 4'b1111;
        for (int k = 0; k < 4; k++) begin bank[k] = 4'b0010; addr[k] = 16'(k); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) begin
                checks++; if (ready1 !== 4'(1 << (c % 4))) $display("FAIL rr_grant c%0d: got %b want %b", c, ready1, 4'(1 << (c % 4))); else passed++;
            end
            if (c >= 1 && c <= 8) begin
                checks++; if (conf1 !== 4'b0010) $display("FAIL rr_conflict c%0d: got %b want 0010", c, conf1); else passed++;
            end
            if (c == 9) begin
                checks++; if (conf1 !== 4'b0000) $display("FAIL rr_conflict_clear: got %b want 0000", conf1); else passed++;
            end
            if (c >= 3 && c <= 10) begin
                checks++; if (rspv1 !== 4'(1 << ((c - 3) % 4))) $display("FAIL rr_rsp c%0d: got %b want %b", c, rspv1, 4'(1 << ((c - 3) % 4))); else passed++;
                checks++; if (rspd1[(c - 3) % 4] !== memval(1, 16'((c - 3) % 4)))
                    $display("FAIL rr_rsp_data c%0d: got %h want %h", c, rspd1[(c - 3) % 4], memval(1, 16'((c - 3) % 4))); else passed++;
            end
            if (c == 11) begin
                checks++; if (rspv1 !== 4'b0000) $display("FAIL rr_rsp_drain: got %b want 0000", rspv1); else passed++;
            end
            tick();
            if (c + 1 >= 8) idle();
        end
    endtask

    task automatic test_mixed();
        valid = 4'b0111;
        bank[0] = 4'b0001; addr[0] = 16'h0020; lns[0] = 1'b0; wdata[0] = 32'h55;
        bank[1] = 4'b0010; addr[1] = 16'h0021; lns[1] = 1'b1;
        bank[2] = 4'b0100; addr[2] = 16'h0022; lns[2] = 1'b1;
        @(negedge clk);
        checks++; if (ready1 !== 4'b0111) $display("FAIL mixed_ready: got %b want 0111", ready1); else passed++;
        tick(); idle();
        @(negedge clk);
        checks++; if ({breq1, we1} !== 8'b0111_0001) $display("FAIL mixed_issue: got %b want 01110001", {breq1, we1}); else passed++;
        checks++; if ({baddr1[0], bwd1[0]} !== {16'h0020, 32'h55}) $display("FAIL mixed_store: got %h/%h want 0020/55", baddr1[0], bwd1[0]); else passed++;
        tick(); @(negedge clk);
        checks++; if ({breq1, we1} !== 8'd0) $display("FAIL mixed_idle_issue: got %b want 0", {breq1, we1}); else passed++;
        checks++; if (baddr1[0] !== 16'h0020) $display("FAIL mixed_addr_hold: got %h want 0020", baddr1[0]); else passed++;
        tick(); @(negedge clk);
        checks++; if (rspv1 !== 4'b0110) $display("FAIL mixed_rsp: got %b want 0110", rspv1); else passed++;
        checks++; if ({rspd1[1], rspd1[2]} !== {memval(1, 16'h21), memval(2, 16'h22)})
            $display("FAIL mixed_rsp_data: got %h/%h want %h/%h", rspd1[1], rspd1[2], memval(1, 16'h21), memval(2, 16'h22)); else passed++;
        tick(); @(negedge clk);
        checks++; if (rspv1 !== 4'b0000) $display("FAIL mixed_no_extra: got %b want 0000", rspv1); else passed++;
    endtask

    task automatic test_illegal();
        tick();
        valid = 4'b1011; lns = 4'b1011;
        bank[0] = 4'b0001; bank[1] = 4'b1000; bank[3] = 4'b0110;
        @(negedge clk);
        checks++; if ({ready1, ill1} !== 5'b0011_0) $display("FAIL illegal_first: got %b want 00110", {ready1, ill1}); else passed++;
        for (int c = 1; c < 4; c++) begin
            tick(); @(negedge clk);
            checks++; if ({ready1, ill1} !== 5'b0011_1) $display("FAIL illegal_hold c%0d: got %b want 00111", c, {ready1, ill1}); else passed++;
            if (c == 1) begin
                checks++; if (breq1 !== 4'b1001) $display("FAIL illegal_issue: got %b want 1001", breq1); else passed++;
            end
        end
        tick(); idle();
        tick(); @(negedge clk);
        checks++; if (ill1 !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", ill1); else passed++;
    endtask

    task automatic test_reset_mid();
        tick();
        valid = 4'b0100; bank[2] = 4'b1000; addr[2] = 16'h0033; lns[2] = 1'b1;
        @(negedge clk);
        checks++; if (ready1 !== 4'b0100) $display("FAIL rstmid_ready: got %b want 0100", ready1); else passed++;
        tick(); idle();
        @(negedge clk);
        checks++; if (breq1 !== 4'b1000) $display("FAIL rstmid_issue: got %b want 1000", breq1); else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({breq1, we1, rspv1, conf1, ill1, breq3} !== 21'd0)
            $display("FAIL rstmid_async: got %b want 0", {breq1, we1, rspv1, conf1, ill1, breq3}); else passed++;
        checks++; if (baddr1[3] !== 16'h0) $display("FAIL rstmid_addr: got %h want 0", baddr1[3]); else passed++;
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if ({rspv1, rspv3} !== 8'd0) $display("FAIL rstmid_stale c%0d: got %b want 0", c, {rspv1, rspv3}); else passed++;
            tick();
        end
        valid = 4'b1111; lns = 4'b1111;
        for (int k = 0; k < 4; k++) bank[k] = 4'b0100;
        @(negedge clk);
        checks++; if (ready1 !== 4'b0001) $display("FAIL rstmid_ptr: got %b want 0001", ready1); else passed++;
        tick(); idle();
    endtask

    task automatic test_lat3_sweep();
        logic [3:0]       expv [8];
        logic [31:0]      expd [8][4];
        int               mptr [4];
        logic [3:0]       exp_rdy;
        logic [3:0]       granted;
        int               j;
        logic             found;
        do_reset();
        for (int s = 0; s < 8; s++) expv[s] = '0;
        for (int b = 0; b < 4; b++) mptr[b] = 0;
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            checks++; if (rspv3 !== expv[c % 8]) $display("FAIL lat3_rsp_valid c%0d: got %b want %b", c, rspv3, expv[c % 8]); else passed++;
            for (int k = 0; k < 4; k++) if (expv[c % 8][k]) begin
                checks++; if (rspd3[k] !== expd[c % 8][k])
                    $display("FAIL lat3_rsp_data c%0d k%0d: got %h want %h", c, k, rspd3[k], expd[c % 8][k]); else passed++;
            end
            expv[c % 8] = '0;
            exp_rdy = '0;
            for (int b = 0; b < 4; b++) begin
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    j = (mptr[b] + i) % 4;
                    if (!found && valid[j] && bank[j][b]) begin
                        found = 1'b1;
                        exp_rdy[j] = 1'b1;
                        mptr[b] = (j + 1) % 4;
                        if (lns[j]) begin
                            expv[(c + 5) % 8][j] = 1'b1;
                            expd[(c + 5) % 8][j] = memval(b, addr[j]);
                        end
                    end
                end
            end
            checks++; if (ready3 !== exp_rdy) $display("FAIL lat3_grant c%0d: got %b want %b", c, ready3, exp_rdy); else passed++;
            granted = exp_rdy;
            tick();
            for (int k = 0; k < 4; k++) begin
                if (granted[k]) valid[k] = 1'b0;
                if (!valid[k] && c < 240 && $urandom_range(0, 3) != 0) begin
                    valid[k] = 1'b1;
                    bank[k]  = 4'(1 << $urandom_range(0, 3));
                    addr[k]  = 16'($urandom);
                    lns[k]   = 1'($urandom);
                    wdata[k] = $urandom;
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_load();
        test_rr_bank1();
        test_mixed();
        test_illegal();
        test_reset_mid();
        test_lat3_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream_bank_arbiter.md
Name: stream_bank_arbiter

Overview:
- Resolves bank conflicts among the address generation engines (AGEs) of one stream group competing for that stream's memory banks.
- Each AGE issues one request per cycle: address, one-hot bank and load/store. Each bank accepts at most one request per cycle.
- Granting is round-robin per bank. Registered requests are driven to the banks, and load data is routed back to the originating AGE through a latency-matched tag pipeline.
- One instance sits per stream between the AGE unit outputs and the stream's bank ports.

Parameters:
- N_REQ, 4: requesters (AGEs) per stream
- N_BANKS, 4: banks per stream
- ADDR_W, 16: bank address width
- DATA_W, 32: data width
- MEM_LAT, 1: bank read latency in cycles, from registered request to rdata valid (≥1)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  request valid per AGE
- req_ready_o  out  N_REQ  grant; a transfer happens when valid & ready
- req_bank_i  in  N_REQ×N_BANKS  one-hot target bank
- req_addr_i  in  N_REQ×ADDR_W  bank-local address
- req_lns_i  in  N_REQ  1 = load, 0 = store
- req_wdata_i  in  N_REQ×DATA_W  store data
- bank_req_o  out  N_BANKS  bank access strobe
- bank_we_o  out  N_BANKS  write enable
- bank_addr_o  out  N_BANKS×ADDR_W  bank address
- bank_wdata_o  out  N_BANKS×DATA_W  bank write data
- bank_rdata_i  in  N_BANKS×DATA_W  bank read data
- rsp_valid_o  out  N_REQ  load response valid
- rsp_rdata_o  out  N_REQ×DATA_W  load response data
- conflict_o  out  N_BANKS  pulse: ≥2 valid requesters targeted this bank this cycle
- illegal_o  out  1  sticky: a valid request carried a non-one-hot bank vector

Behaviour:
- Reset: every output register goes to 0, including bank_*, rsp_*, conflict_o and illegal_o. All RR pointers go to 0 and all tag pipelines are cleared.
- A reset asserted mid-operation discards in-flight responses. No rsp_valid_o is produced for them after release.
- Grant (combinational, cycle t):
  - For each bank b, the candidates are requesters with req_valid_i & req_bank_i[b].
  - The winner is the first candidate at or after ptr[b], scanning upward modulo N_REQ.
  - req_ready_o[k] = 1 iff k wins its bank. The grant does not depend on req_ready_o, so there is no combinational loop.
- Pointer update: on a grant to k, ptr[b] ← (k+1) mod N_REQ at t+1. With no grant, ptr[b] holds.
- Non-one-hot bank vector (zero or multi-hot): the request is never granted and illegal_o is set from t+1 until reset. Other requesters are unaffected.
- Losers must hold valid/addr/bank/lns/wdata stable until granted. A held request is always granted within N_REQ cycles, so there is no starvation.
- Issue (registered, cycle t+1):
  - bank_req_o[b] = 1.
  - bank_we_o[b] = ~lns.
  - bank_addr_o and bank_wdata_o are taken from the winner.
  - Without a grant, bank_req_o = 0, bank_we_o = 0, and addr/wdata hold their previous value.
- Tag pipeline:
  - Per bank, a MEM_LAT+1 stage shift register of {load_valid, src index [$clog2(N_REQ)-1:0]}, loaded at issue.
  - Stores enter with load_valid = 0.
- Response (cycle t+1+MEM_LAT): bank_rdata_i[b] is valid. It is registered into rsp_rdata_o[src] with rsp_valid_o[src] = 1 at t+2+MEM_LAT.
  - Total load latency from grant to response: MEM_LAT+2 cycles.
  - A requester wins at most one bank per cycle, so at most one response targets each requester per cycle; no merge is needed.
  - rsp_rdata_o holds its value when rsp_valid_o = 0.
- Throughput: one request per bank per cycle. Back-to-back grants to the same requester on different banks in consecutive cycles are legal.
- conflict_o[b] is registered at t+1 from the cycle-t candidate count being ≥2.

Decomposition:
- mage_pkg:
  - DATA_W, ADDR_W and MEM_LAT defaults.
  - Tag struct typedef {logic load_valid; logic [$clog2(N_REQ)-1:0] src;}.
  - Reuse N_AGE_PER_STREAM → N_REQ and N_BANKS_PER_STREAM → N_BANKS.
- Sub-module rr_arbiter (N_REQ requests → one-hot grant + internal pointer), instantiated once per bank.
- The tag pipeline and response routing stay in the top module.

Test Plan:
- Single load, AGE0→bank2, addr 0x10, MEM_LAT=1 → ready[0] at t0; bank_req_o[2]=1, we=0, addr 0x10 at t0+1; rdata 0xCAFE returned at t0+2 appears as rsp_valid_o[0], rsp_rdata_o[0]=0xCAFE at t0+3.
- All 4 AGEs load from bank1 continuously, ptr=0 → grants 0,1,2,3,0 on consecutive cycles; conflict_o[1]=1 every cycle; each AGE receives exactly one response per 4 cycles.
- AGE0→bank0 store 0x55, AGE1→bank1 load, AGE2→bank2 load, same cycle → all three ready; bank_we_o=3'b001 on banks 0..2; responses only on AGE1 and AGE2, none on AGE0.
- AGE3 req_bank=4'b0110 valid → ready[3] never asserts; illegal_o=1 from the next cycle and stays set; other AGEs are granted normally.
- Assert rst_n_i=0 one cycle after a load issue → all outputs 0 immediately; after release, no stale rsp_valid_o and ptr=0.
- MEM_LAT=3 sweep with random traffic → scoreboard checks every load response arrives after exactly 5 cycles at the correct requester with the correct data.
